// File: rtl/branch_ctrl_if.sv
// Signal bundle between decode/fetch/comparator (master) and branch_ctrl (slave).
interface branch_ctrl_if #(
  parameter int RegWidth  = 32,
  parameter int StatWidth = 32
);
  logic                 iValid;
  logic                 oReady;
  logic [2:0]           iFunc3;
  logic [RegWidth-1:0]  iPC;
  logic [RegWidth-1:0]  iImm;
  logic                 iPredTaken;
  logic                 iOpsValid;
  logic [RegWidth-1:0]  iRs1;
  logic [RegWidth-1:0]  iRs2;
  logic                 iKill;
  logic [RegWidth-1:0]  oCmpRs1;
  logic [RegWidth-1:0]  oCmpRs2;
  logic [2:0]           oCmpFunc3;
  logic                 iCmpTrue;
  logic                 oStall;
  logic                 oBrValid;
  logic                 oBrTaken;
  logic                 oMispredict;
  logic                 oIllegal;
  logic                 oFlush;
  logic [RegWidth-1:0]  oRedirectPC;
  logic                 iFetchReady;
  logic [StatWidth-1:0] oBrCount;
  logic [StatWidth-1:0] oMispCount;

  modport master (
    output iValid, iFunc3, iPC, iImm, iPredTaken, iOpsValid, iRs1, iRs2, iKill,
           iCmpTrue, iFetchReady,
    input  oReady, oCmpRs1, oCmpRs2, oCmpFunc3, oStall, oBrValid, oBrTaken,
           oMispredict, oIllegal, oFlush, oRedirectPC, oBrCount, oMispCount
  );

  modport slave (
    input  iValid, iFunc3, iPC, iImm, iPredTaken, iOpsValid, iRs1, iRs2, iKill,
           iCmpTrue, iFetchReady,
    output oReady, oCmpRs1, oCmpRs2, oCmpFunc3, oStall, oBrValid, oBrTaken,
           oMispredict, oIllegal, oFlush, oRedirectPC, oBrCount, oMispCount
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a branch, waits for operands, resolves, redirects fetch.
// Optional statistics counters are built when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl #(
  parameter int RegWidth  = 32,
  parameter int StatWidth = 32
) (
  input  logic         iClk,
  input  logic         iRstN,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OPS,
    ST_EVAL,
    ST_REDIRECT
  } state_t;

  localparam logic [RegWidth-1:0] PcStep = RegWidth'(4);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_func3;
  logic [RegWidth-1:0] r_pc;
  logic [RegWidth-1:0] r_imm;
  logic                r_pred;
  logic [RegWidth-1:0] r_rs1;
  logic [RegWidth-1:0] r_rs2;
  logic [RegWidth-1:0] r_redirect_pc;

  logic w_accept;
  logic w_ops_load;
  logic w_fire;
  logic w_ready;
  logic w_stall;
  logic w_flush;
  logic w_legal;
  logic w_taken;
  logic w_misp;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ops_load = 1'b0;
    w_fire     = 1'b0;
    w_ready    = 1'b0;
    w_stall    = 1'b0;
    w_flush    = 1'b0;
    w_legal    = (r_func3[2:1] != 2'b01);
    w_taken    = bus.iCmpTrue && w_legal;
    w_misp     = (w_taken != r_pred);

    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.iValid && !bus.iKill) begin
          w_accept = 1'b1;
          if (bus.iOpsValid) begin
            w_ops_load = 1'b1;
            w_next     = ST_EVAL;
          end else begin
            w_next = ST_WAIT_OPS;
          end
        end
      end
      ST_WAIT_OPS: begin
        w_stall = 1'b1;
        if (bus.iKill) begin
          w_next = ST_IDLE;
        end else if (bus.iOpsValid) begin
          w_ops_load = 1'b1;
          w_next     = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (bus.iKill) begin
          w_next = ST_IDLE;
        end else begin
          w_fire = 1'b1;
          w_next = w_misp ? ST_REDIRECT : ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        // A kill from an older flush cannot cancel a redirect already in progress.
        w_flush = 1'b1;
        if (bus.iFetchReady) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: capture registers are cleared too, so the comparator never sees stale operands after reset.
    if (!iRstN) begin
      r_func3       <= '0;
      r_pc          <= '0;
      r_imm         <= '0;
      r_pred        <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_redirect_pc <= '0;
    end else begin
      if (w_accept) begin
        r_func3 <= bus.iFunc3;
        r_pc    <= bus.iPC;
        r_imm   <= bus.iImm;
        r_pred  <= bus.iPredTaken;
      end
      if (w_ops_load) begin
        r_rs1 <= bus.iRs1;
        r_rs2 <= bus.iRs2;
      end
      if (w_fire) begin
        r_redirect_pc <= w_taken ? (r_pc + r_imm) : (r_pc + PcStep);
      end
    end
  end

  assign bus.oReady      = w_ready;
  assign bus.oStall      = w_stall;
  assign bus.oFlush      = w_flush;
  assign bus.oBrValid    = w_fire;
  assign bus.oBrTaken    = w_fire && w_taken;
  assign bus.oMispredict = w_fire && w_misp;
  assign bus.oIllegal    = w_fire && !w_legal;
  assign bus.oRedirectPC = r_redirect_pc;
  assign bus.oCmpRs1     = r_rs1;
  assign bus.oCmpRs2     = r_rs2;
  assign bus.oCmpFunc3   = r_func3;

`ifdef BRANCH_CTRL_STATS_EN
  logic [StatWidth-1:0] r_br_count;
  logic [StatWidth-1:0] r_misp_count;

  // Counters wrap naturally from all-ones to zero.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_br_count   <= '0;
      r_misp_count <= '0;
    end else if (w_fire) begin
      r_br_count <= r_br_count + StatWidth'(1);
      if (w_misp) begin
        r_misp_count <= r_misp_count + StatWidth'(1);
      end
    end
  end

  assign bus.oBrCount   = r_br_count;
  assign bus.oMispCount = r_misp_count;
`else
  assign bus.oBrCount   = {StatWidth{1'b0}};
  assign bus.oMispCount = {StatWidth{1'b0}};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: transaction-level expectations, per-cycle compare, directed + random.
module tb_branch_ctrl;
  localparam int RW = 32;
  localparam int SW = 4;

`ifdef BRANCH_CTRL_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  always #5 iClk = ~iClk;

  branch_ctrl_if #(.RegWidth(RW), .StatWidth(SW)) bus ();
  branch_ctrl #(.RegWidth(RW), .StatWidth(SW)) dut (.iClk(iClk), .iRstN(iRstN), .bus(bus));

  // External comparator; reports true for reserved codes so the controller's gating is exercised.
  function automatic logic cmp_ref(input logic [2:0] f, input logic [RW-1:0] a, input logic [RW-1:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  always_comb bus.iCmpTrue = cmp_ref(bus.oCmpFunc3, bus.oCmpRs1, bus.oCmpRs2);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expectations for the current cycle, written by the driver.
  bit          e_en = 1'b0;
  bit          e_ready, e_stall, e_brv, e_taken, e_misp, e_ill, e_flush;
  bit          e_chk_cmp, e_chk_rpc;
  logic [RW-1:0] e_rs1, e_rs2, e_rpc;
  logic [2:0]  e_f3;
  int          m_br   = 0;
  int          m_misp = 0;

  // Observations used by the directed literal checks.
  int          cyc = 0;
  int          n_brv, n_flush, n_stall, o_brv_cyc;
  logic        o_taken, o_misp, o_ill;
  logic [RW-1:0] o_rpc;
  logic [SW-1:0] exp_br, exp_misp;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (e_en) begin
      exp_br   = StatsOn ? SW'(m_br)   : '0;
      exp_misp = StatsOn ? SW'(m_misp) : '0;
      check("oReady",      bus.oReady,      e_ready);
      check("oStall",      bus.oStall,      e_stall);
      check("oBrValid",    bus.oBrValid,    e_brv);
      check("oBrTaken",    bus.oBrTaken,    e_taken);
      check("oMispredict", bus.oMispredict, e_misp);
      check("oIllegal",    bus.oIllegal,    e_ill);
      check("oFlush",      bus.oFlush,      e_flush);
      check("oBrCount",    bus.oBrCount,    exp_br);
      check("oMispCount",  bus.oMispCount,  exp_misp);
      if (e_chk_cmp) begin
        check("oCmpRs1",   bus.oCmpRs1,   e_rs1);
        check("oCmpRs2",   bus.oCmpRs2,   e_rs2);
        check("oCmpFunc3", bus.oCmpFunc3, e_f3);
      end
      if (e_chk_rpc) check("oRedirectPC", bus.oRedirectPC, e_rpc);
      if (bus.oBrValid) begin
        n_brv++;
        o_brv_cyc = cyc;
        o_taken   = bus.oBrTaken;
        o_misp    = bus.oMispredict;
        o_ill     = bus.oIllegal;
      end
      if (bus.oStall) n_stall++;
      if (bus.oFlush) begin
        n_flush++;
        o_rpc = bus.oRedirectPC;
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_obs();
    n_brv = 0; n_flush = 0; n_stall = 0; o_brv_cyc = -1;
    o_taken = 1'bx; o_misp = 1'bx; o_ill = 1'bx; o_rpc = 'x;
  endtask

  task automatic set_exp(input bit ready, input bit stall);
    e_en = 1'b1; e_ready = ready; e_stall = stall;
    e_brv = 1'b0; e_taken = 1'b0; e_misp = 1'b0; e_ill = 1'b0; e_flush = 1'b0;
    e_chk_cmp = 1'b0; e_chk_rpc = 1'b0;
  endtask

  task automatic scramble();
    bus.iValid      = 1'($urandom);
    bus.iFunc3      = 3'($urandom);
    bus.iPC         = $urandom;
    bus.iImm        = $urandom;
    bus.iPredTaken  = 1'($urandom);
    bus.iOpsValid   = 1'($urandom);
    bus.iRs1        = $urandom;
    bus.iRs2        = $urandom;
    bus.iKill       = 1'($urandom);
    bus.iFetchReady = 1'($urandom);
  endtask

  task automatic drive_idle(input bit try_kill);
    scramble();
    bus.iValid = try_kill;
    if (try_kill) bus.iKill = 1'b1;
    set_exp(1'b1, 1'b0);
  endtask

  task automatic expect_cleared();
    e_chk_cmp = 1'b1; e_rs1 = '0; e_rs2 = '0; e_f3 = '0;
    e_chk_rpc = 1'b1; e_rpc = '0;
  endtask

  task automatic do_reset();
    drive_idle(1'b0);
    e_en  = 1'b0;
    iRstN = 1'b0;
    step();
    m_br = 0; m_misp = 0;
    drive_idle(1'b0);
    expect_cleared();
    step();
    iRstN = 1'b1;
    drive_idle(1'b0);
    expect_cleared();
  endtask

  // One branch from acceptance in the current (idle) cycle to completion; ends with an idle cycle set up.
  task automatic run_branch(input logic [2:0] f3, input logic [RW-1:0] pc, input logic [RW-1:0] imm,
                            input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input bit pred,
                            input int ops_delay, input int kill_at, input int fetch_delay,
                            input bit rst_redirect, output int t_accept);
    bit legal, taken, misp;
    logic [RW-1:0] tgt;
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    taken = legal && cmp_ref(f3, rs1, rs2);
    misp  = (taken != pred);
    tgt   = taken ? pc + imm : pc + RW'(4);
    t_accept = cyc;

    scramble();
    bus.iValid = 1'b1; bus.iKill = 1'b0; bus.iFunc3 = f3; bus.iPC = pc; bus.iImm = imm;
    bus.iPredTaken = pred; bus.iOpsValid = (ops_delay == 0);
    if (ops_delay == 0) begin bus.iRs1 = rs1; bus.iRs2 = rs2; end
    if (fetch_delay == 0) bus.iFetchReady = 1'b1;
    set_exp(1'b1, 1'b0);
    step();

    for (int w = 1; w <= ops_delay; w++) begin
      scramble();
      bus.iKill     = (kill_at == w);
      bus.iOpsValid = (w == ops_delay);
      if (w == ops_delay) begin bus.iRs1 = rs1; bus.iRs2 = rs2; end
      if (fetch_delay == 0) bus.iFetchReady = 1'b1;
      set_exp(1'b0, 1'b1);
      step();
      if (kill_at == w) begin drive_idle(1'b0); return; end
    end

    scramble();
    bus.iKill = (kill_at == ops_delay + 1);
    if (fetch_delay == 0) bus.iFetchReady = 1'b1;
    set_exp(1'b0, 1'b0);
    e_chk_cmp = 1'b1; e_rs1 = rs1; e_rs2 = rs2; e_f3 = f3;
    if (kill_at != ops_delay + 1) begin
      e_brv = 1'b1; e_taken = taken; e_misp = misp; e_ill = !legal;
    end
    step();
    if (kill_at == ops_delay + 1) begin drive_idle(1'b0); return; end
    m_br++;
    if (misp) m_misp++;

    if (misp) begin
      for (int r = 0; r < 64; r++) begin
        scramble();
        bus.iFetchReady = (r >= fetch_delay) && !(rst_redirect && r <= 1);
        if (rst_redirect && r == 1) iRstN = 1'b0;
        set_exp(1'b0, 1'b0);
        e_flush = 1'b1; e_chk_rpc = 1'b1; e_rpc = tgt;
        e_chk_cmp = 1'b1; e_rs1 = rs1; e_rs2 = rs2; e_f3 = f3;
        step();
        if (rst_redirect && r == 1) begin
          iRstN = 1'b1;
          m_br = 0; m_misp = 0;
          drive_idle(1'b0);
          expect_cleared();
          return;
        end
        if (bus.iFetchReady) break;
      end
    end
    drive_idle(1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [2:0] f3;
    logic [RW-1:0] rs1, rs2;
    int od, ka, fd;
    bit rr;

    clear_obs();
    do_reset();
    check("rst_ready",  bus.oReady,   1'b1);
    check("rst_cmprs1", bus.oCmpRs1,  '0);
    step();

    // BEQ 5==5, predicted taken, operands ready on accept.
    clear_obs();
    run_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 0, -1, 0, 1'b0, t0);
    check("beq_latency", o_brv_cyc - t0, 1);
    check("beq_taken",   o_taken, 1'b1);
    check("beq_misp",    o_misp,  1'b0);
    check("beq_flush",   n_flush, 0);

    // BLT -1<1, predicted not taken, operands three cycles late.
    clear_obs();
    run_branch(3'b100, 32'h200, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 1'b0, 3, -1, 2, 1'b0, t0);
    check("blt_stall",   n_stall, 3);
    check("blt_latency", o_brv_cyc - t0, 4);
    check("blt_taken",   o_taken, 1'b1);
    check("blt_misp",    o_misp,  1'b1);
    check("blt_rpc",     o_rpc,   32'h1F8);
    check("blt_flush",   n_flush, 3);

    // BGEU 1 >= 0xFFFFFFFF false; fall-through wraps to zero; fetch already ready.
    clear_obs();
    run_branch(3'b111, 32'hFFFF_FFFC, 32'h40, 32'd1, 32'hFFFF_FFFF, 1'b1, 0, -1, 0, 1'b0, t0);
    check("bgeu_taken", o_taken, 1'b0);
    check("bgeu_misp",  o_misp,  1'b1);
    check("bgeu_rpc",   o_rpc,   32'h0);
    check("bgeu_flush", n_flush, 1);

    // Kill while waiting for operands.
    clear_obs();
    run_branch(3'b000, 32'h300, 32'h8, 32'd7, 32'd7, 1'b0, 2, 1, 1, 1'b0, t0);
    check("killwait_brv",   n_brv,   0);
    check("killwait_flush", n_flush, 0);
    step();

    // Kill in the evaluation cycle.
    clear_obs();
    run_branch(3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0, 1, 2, 0, 1'b0, t0);
    check("killeval_brv", n_brv, 0);

    // Reserved funct3 010: illegal, never taken even though the comparator says true.
    clear_obs();
    run_branch(3'b010, 32'h500, 32'h30, 32'd3, 32'd3, 1'b0, 0, -1, 0, 1'b0, t0);
    check("ill_flag",  o_ill,   1'b1);
    check("ill_taken", o_taken, 1'b0);
    check("ill_misp",  o_misp,  1'b0);

    // Kill in idle together with valid: nothing is accepted.
    clear_obs();
    drive_idle(1'b1);
    step();
    drive_idle(1'b0);
    step();
    check("idlekill_brv", n_brv, 0);

    // Reset while redirecting abandons the branch.
    clear_obs();
    run_branch(3'b000, 32'h600, 32'h40, 32'd1, 32'd1, 1'b0, 0, -1, 3, 1'b1, t0);
    step();
    check("rstredir_flush", n_flush, 2);

    // 17 branches, 2 mispredicts, 4-bit counters.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_branch(3'b000, $urandom, $urandom, 32'd9, 32'd9, !(i == 4 || i == 9),
                 $urandom_range(0, 2), -1, $urandom_range(0, 2), 1'b0, t0);
    end
    check("stat17_br",   bus.oBrCount,   StatsOn ? 4'd1 : 4'd0);
    check("stat17_misp", bus.oMispCount, StatsOn ? 4'd2 : 4'd0);

    for (int n = 0; n < 300; n++) begin
      f3  = 3'($urandom);
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      od  = $urandom_range(0, 3);
      ka  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, od + 1)) : -1;
      fd  = $urandom_range(0, 3);
      rr  = ($urandom_range(0, 19) == 0);
      run_branch(f3, $urandom, $urandom, rs1, rs2, 1'($urandom), od, ka, fd, rr, t0);
      repeat ($urandom_range(0, 2)) begin
        drive_idle(1'($urandom));
        step();
      end
    end

    e_en = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: StatWidth, 32, width of the branch statistics counters.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 iClk  in  1  clock; all state updates on rising edge.
REQ-004 iRstN  in  1  synchronous active-low reset.
REQ-005 iValid  in  1  decode presents a branch.
REQ-006 oReady  out  1  block can accept a branch.
REQ-007 iFunc3  in  3  branch funct3.
REQ-008 iPC, iImm  in  RegWidth each  branch PC and sign-extended B-immediate.
REQ-009 iPredTaken  in  1  fetch prediction for this branch.
REQ-010 iOpsValid  in  1  iRs1/iRs2 hold final forwarded values this cycle.
REQ-011 iRs1, iRs2  in  RegWidth each  operand values.
REQ-012 iKill  in  1  abort in-flight branch (older-instruction flush).
REQ-013 oCmpRs1, oCmpRs2  out  RegWidth each; oCmpFunc3  out  3; these drive the branch comparator.
REQ-014 iCmpTrue  in  1  combinational comparator result.
REQ-015 oStall  out  1  hold decode; the branch is waiting for operands.
REQ-016 oBrValid  out  1  one-cycle resolution pulse; oBrTaken, oMispredict, oIllegal  out  1 each  are qualified by oBrValid.
REQ-017 oFlush  out  1  redirect request; oRedirectPC  out  RegWidth  its target; iFetchReady  in  1  fetch accepts the redirect.
REQ-018 oBrCount, oMispCount  out  StatWidth each  statistics counters.

Function
REQ-019 FSM states: IDLE, WAIT_OPS, EVAL, REDIRECT.
REQ-020 IDLE: oReady=1. On iValid&&!iKill, capture func3, PC, imm and predTaken. Go to EVAL if iOpsValid, capturing iRs1/iRs2 in the same cycle; otherwise go to WAIT_OPS.
REQ-021 WAIT_OPS: oReady=0, oStall=1. On iOpsValid, capture the operands and go to EVAL.
REQ-022 oCmpRs1/oCmpRs2/oCmpFunc3 SHALL always come from the capture registers; iCmpTrue is sampled only in EVAL.
REQ-023 EVAL lasts one cycle with oBrValid=1:
- oBrTaken = iCmpTrue && legal funct3.
- oMispredict = oBrTaken != captured predTaken.
- Next state is REDIRECT on mispredict, otherwise IDLE.
- Latency from accept to oBrValid is 1 cycle plus operand wait.
REQ-024 Redirect target is captured in EVAL: PC+imm if taken, else PC+4. Both sums are modulo 2^RegWidth; carry-out is dropped.
REQ-025 funct3 010 or 011: oIllegal=1, oBrTaken=0, and misprediction is evaluated normally.
REQ-026 REDIRECT: oFlush=1 and oRedirectPC is held stable until iFetchReady=1, then the FSM goes to IDLE. A redirect lasts at least 1 cycle even if iFetchReady is already high.
REQ-027 iKill in WAIT_OPS or EVAL: the FSM goes to IDLE next cycle, and oBrValid, oFlush and counter updates are suppressed.
REQ-028 iKill in REDIRECT: ignored; the redirect completes.
REQ-029 iKill in IDLE together with iValid: kill wins and the branch is not accepted.
REQ-030 Outputs other than oRedirectPC/oCmp* SHALL be 0 when not asserted by the current state.

Reset
REQ-031 When iRstN=0 at a clock edge:
- State goes to IDLE; capture registers and counters are cleared.
- oStall, oBrValid, oFlush, oBrTaken, oMispredict and oIllegal are 0.
- oReady is 1 from the first cycle after reset.
REQ-032 Reset asserted mid-operation (any state, including REDIRECT with oFlush high) SHALL abandon the branch with no pulse emitted.

Configuration
REQ-033 Macro BRANCH_CTRL_STATS_EN:
- Defined: oBrCount increments on every oBrValid; oMispCount increments on every oBrValid&&oMispredict. Both wrap from all-ones to 0.
- Undefined: counters are not built and both ports are tied to 0.

Verification
REQ-034 BEQ, Rs1=Rs2=5, iOpsValid same cycle, pred=1, PC=0x100, imm=0x20 -> oBrValid 1 cycle later, taken=1, no mispredict, no flush.
REQ-035 BLT, Rs1=-1, Rs2=1, pred=0, iOpsValid delayed 3 cycles, PC=0x200, imm=-8 -> oStall high 3 cycles, mispredict=1, oFlush with oRedirectPC=0x1F8 held until iFetchReady.
REQ-036 BGEU, Rs1=1, Rs2=0xFFFFFFFF, pred=1, PC=0xFFFFFFFC -> taken=0, mispredict=1, oRedirectPC=0x00000000 (wrap).
REQ-037 iKill asserted in WAIT_OPS -> IDLE next cycle, no oBrValid, no oFlush, counters unchanged; funct3=010 -> oIllegal=1, oBrTaken=0.
REQ-038 With BRANCH_CTRL_STATS_EN, StatWidth=4: 17 branches with 2 mispredicts -> oBrCount=1, oMispCount=2; without the macro both read 0.
